// File: rtl/ysyx_22041211_pkg.sv
// ysyx_22041211_pkg: fetch FSM state encoding, NOP word and default reset PC
package ysyx_22041211_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, HOLD = 2'd3} ifu_state_e;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/ysyx_22041211_ifu_if.sv
// ysyx_22041211_ifu_if: memory request/response and controller handshake bundle
interface ysyx_22041211_ifu_if;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  modport master (
    output req_valid_o, req_addr_o, valid_o, inst_o, pc_o,
    input  req_ready_i, rsp_valid_i, rsp_data_i, branch_flag_i, branch_target_i, ready_i
  );
  modport slave (
    input  req_valid_o, req_addr_o, valid_o, inst_o, pc_o,
    output req_ready_i, rsp_valid_i, rsp_data_i, branch_flag_i, branch_target_i, ready_i
  );
endinterface

// File: rtl/ysyx_22041211_pc_reg.sv
// ysyx_22041211_pc_reg: program counter with reset > redirect > increment priority
module ysyx_22041211_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_target,
  input  logic        i_inc,
  output logic [31:0] o_pc
);
  logic [31:0] r_pc;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_pc <= RESET_PC;
    else r_pc <= i_load ? (i_target & 32'hFFFF_FFFC) : i_inc ? r_pc + 32'd4 : r_pc;
  assign o_pc = r_pc;
endmodule

// File: rtl/ysyx_22041211_ifu.sv
// ysyx_22041211_ifu: instruction fetch FSM with redirect and in-flight response drop.
// Define YSYX_22041211_IFU_PERF_EN to add perf_fetch_o/perf_stall_o counters.
module ysyx_22041211_ifu
  import ysyx_22041211_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input logic clk,
  input logic rst,
  ysyx_22041211_ifu_if.master bus
`ifdef YSYX_22041211_IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_stall_o
`endif
);
  ifu_state_e  r_state, w_next;
  logic        r_drop, w_drop, w_br, w_take;
  logic [31:0] r_addr, r_inst, r_pc_o, w_pc;
  assign w_br   = bus.branch_flag_i & (r_state != IDLE);
  assign w_take = (r_state == WAIT) & bus.rsp_valid_i & ~r_drop & ~bus.branch_flag_i;
  always_comb begin
    w_next = r_state;
    w_drop = r_drop;
    case (r_state)
      IDLE: w_next = REQ;
      REQ: begin
        w_next = bus.req_ready_i ? WAIT : REQ;
        w_drop = r_drop | bus.branch_flag_i;
      end
      WAIT: begin
        w_next = bus.rsp_valid_i ? (w_take ? HOLD : REQ) : WAIT;
        w_drop = ~bus.rsp_valid_i & (r_drop | bus.branch_flag_i);
      end
      default: w_next = (bus.branch_flag_i | bus.ready_i) ? REQ : HOLD;
    endcase
  end
  // r_addr freezes the pre-redirect address while a redirected request is still unaccepted
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_drop  <= 1'b0;
      r_addr  <= RESET_PC;
      r_inst  <= NOP;
      r_pc_o  <= RESET_PC;
    end else begin
      r_state <= w_next;
      r_drop  <= w_drop;
      r_addr  <= r_drop ? r_addr : w_pc;
      r_inst  <= w_take ? bus.rsp_data_i : r_inst;
      r_pc_o  <= w_take ? w_pc : r_pc_o;
    end
  ysyx_22041211_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .i_load(w_br),
    .i_target(bus.branch_target_i),
    .i_inc((r_state == HOLD) & bus.ready_i),
    .o_pc(w_pc)
  );
  assign bus.req_valid_o = r_state == REQ;
  assign bus.req_addr_o  = r_drop ? r_addr : w_pc;
  assign bus.valid_o     = r_state == HOLD;
  assign bus.inst_o      = r_inst;
  assign bus.pc_o        = r_pc_o;
`ifdef YSYX_22041211_IFU_PERF_EN
  logic [31:0] r_fetch, r_stall;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_fetch <= 32'd0;
      r_stall <= 32'd0;
    end else begin
      r_fetch <= r_fetch + {31'd0, bus.valid_o & bus.ready_i};
      r_stall <= r_stall + {31'd0, (r_state == REQ) | (r_state == WAIT)};
    end
  assign perf_fetch_o = r_fetch;
  assign perf_stall_o = r_stall;
`endif
endmodule

// File: doc/ysyx_22041211_ifu.md
YSYX_22041211_IFU -- requirements
Module: ysyx_22041211_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid_o  output  1  fetch request valid to instruction memory.
REQ-005 SHALL have port req_addr_o  output  32  fetch address, word aligned.
REQ-006 SHALL have port req_ready_i  input  1  memory accepts the request.
REQ-007 SHALL have port rsp_valid_i  input  1  memory response valid.
REQ-008 SHALL have port rsp_data_i  input  32  fetched instruction word.
REQ-009 SHALL have port branch_flag_i  input  1  redirect request from downstream.
REQ-010 SHALL have port branch_target_i  input  32  redirect target PC.
REQ-011 SHALL have port valid_o  output  1  inst_o/pc_o valid to the controller stage.
REQ-012 SHALL have port ready_i  input  1  controller stage accepts inst_o/pc_o.
REQ-013 SHALL have port inst_o  output  32  instruction feeding controller inst_i.
REQ-014 SHALL have port pc_o  output  32  PC of inst_o, feeding controller pc_i.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT, HOLD, with the encoding defined in the package.
REQ-016 SHALL go IDLE->REQ unconditionally one cycle after rst deasserts.
REQ-017 SHALL drive req_valid_o=1 only in REQ, with req_addr_o=pc; REQ->WAIT on req_valid_o&req_ready_i.
REQ-018 SHALL hold req_addr_o stable while req_valid_o=1 and req_ready_i=0, including across a redirect.
REQ-019 SHALL, in WAIT on rsp_valid_i, capture rsp_data_i into inst_o and pc into pc_o, then go to HOLD with valid_o=1 the next cycle.
REQ-020 SHALL, in HOLD, keep valid_o, inst_o and pc_o stable until valid_o&ready_i; then pc<=pc+4 (modulo 2^32), valid_o<=0, and go to REQ.
REQ-021 SHALL give a minimum latency of 3 cycles from request acceptance to the next request (REQ, WAIT, HOLD each one cycle when the other side is ready).
REQ-022 SHALL, on branch_flag_i in HOLD, set pc<=branch_target_i, drop valid_o next cycle without a handshake, and go to REQ.
REQ-023 SHALL, on branch_flag_i in REQ or WAIT, set pc<=branch_target_i and set a drop flag; the in-flight response SHALL be discarded (no valid_o), and the FSM SHALL return to REQ.
REQ-024 SHALL give branch_flag_i priority over a same-cycle valid_o&ready_i handshake: pc<=branch_target_i, not pc+4.
REQ-025 SHALL, on a second redirect while the drop flag is set, keep only the newest target, and discard exactly one response.
REQ-026 SHALL ignore rsp_valid_i in IDLE, REQ and HOLD.
REQ-027 SHALL force branch_target_i[1:0] to 2'b00 when loading pc.

Reset
REQ-028 SHALL, while rst=1, asynchronously force state=IDLE, pc=RESET_PC, drop flag=0, req_valid_o=0, valid_o=0, inst_o=32'h0000_0013 (nop) and pc_o=RESET_PC.
REQ-029 SHALL, on rst mid-operation, abandon any outstanding request; responses arriving after reset SHALL be ignored until a new request is accepted.

Configuration
REQ-030 SHALL, when YSYX_22041211_IFU_PERF_EN is defined, add outputs perf_fetch_o[31:0], counting valid_o&ready_i handshakes, and perf_stall_o[31:0], counting cycles in REQ or WAIT; both SHALL reset to 0 and wrap at 2^32.
REQ-031 SHALL, when YSYX_22041211_IFU_PERF_EN is undefined, omit these ports and counters entirely, with all other behaviour unchanged.

Structure
REQ-032 SHALL place the FSM state typedef, the NOP constant (32'h0000_0013) and the default RESET_PC in the shared package ysyx_22041211_pkg.
REQ-033 SHALL instantiate one sub-module, ysyx_22041211_pc_reg, which holds pc and applies reset/redirect/increment priority (rst > branch > handshake increment).

Verification
REQ-034 SHALL cover reset release with req_ready_i=1 and 1-cycle memory: req_addr_o sequence 0x80000000, 0x80000004, 0x80000008, and valid_o rising 2 cycles after each acceptance.
REQ-035 SHALL cover ready_i=0 for 5 cycles in HOLD: inst_o/pc_o stable and no new request issued; the request for pc_o+4 SHALL start the cycle after ready_i=1.
REQ-036 SHALL cover branch_flag_i=1 with target 0x80000100 in WAIT: the pending response is dropped with no valid_o, and the next req_addr_o=0x80000100.
REQ-037 SHALL cover req_ready_i=0 for 3 cycles plus a redirect to 0x80000200: address held, response dropped, next request to 0x80000200.
REQ-038 SHALL cover a same-cycle handshake and redirect to 0x80000300: next req_addr_o=0x80000300, not pc_o+4.
REQ-039 SHALL cover rst asserted in WAIT, then rsp_valid_i after release: the response is ignored and fetch restarts at 0x80000000.
